// File: rtl/ca_code_gen.sv
// ca_code_gen -- GPS L1 C/A Gold-code generator driven by the code NCO MSB.
//
// Every edge of the code NCO phase MSB is a half-chip tick. Two ticks make
// one chip. The generator produces early/prompt/late replicas at half-chip
// spacing, the current chip index and a one-cycle code-epoch strobe.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active-low
//   enable         in   low: ticks ignored, state held (edge tracking runs)
//   load           in   synchronous code restart; latches tap_a/tap_b
//   tap_a, tap_b   in   G2 phase-select taps (1..10; others contribute 0)
//   code_phase_msb in   MSB of the code NCO phase accumulator
//   early          out  current generator chip
//   prompt         out  early delayed by one half-chip tick
//   late           out  early delayed by two half-chip ticks
//   chip_index     out  index of the current early chip, 0..CHIPS-1
//   epoch          out  one-cycle pulse when early starts chip 0
module ca_code_gen #(
  parameter int CHIPS = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] tap_a,
  input  logic [3:0] tap_b,
  input  logic       code_phase_msb,
  output logic       early,
  output logic       prompt,
  output logic       late,
  output logic [9:0] chip_index,
  output logic       epoch
);

  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  logic [3:0]  ta_q, ta_d;
  logic [3:0]  tb_q, tb_d;
  logic        h_q, h_d;
  logic        msb_q;
  logic [9:0]  idx_q, idx_d;
  logic        prompt_q, prompt_d;
  logic        late_q, late_d;
  logic        epoch_q, epoch_d;

  logic        tick;
  logic        acc_tick;
  logic        early_w;

  // Out-of-range taps select nothing rather than aliasing a stage.
  function automatic logic sel(input logic [10:1] g, input logic [3:0] t);
    logic r;
    r = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) begin
      if (t == 4'(i)) r = g[i];
    end
    return r;
  endfunction

  assign tick     = code_phase_msb ^ msb_q;
  assign acc_tick = tick & enable & ~load;
  assign early_w  = g1_q[10] ^ sel(g2_q, ta_q) ^ sel(g2_q, tb_q);

  always_comb begin
    g1_d     = g1_q;
    g2_d     = g2_q;
    ta_d     = ta_q;
    tb_d     = tb_q;
    h_d      = h_q;
    idx_d    = idx_q;
    prompt_d = prompt_q;
    late_d   = late_q;
    epoch_d  = 1'b0;

    if (load) begin
      g1_d     = '1;
      g2_d     = '1;
      idx_d    = '0;
      h_d      = 1'b0;
      prompt_d = 1'b0;
      late_d   = 1'b0;
      ta_d     = tap_a;
      tb_d     = tap_b;
    end else if (acc_tick) begin
      h_d      = ~h_q;
      late_d   = prompt_q;
      prompt_d = early_w;
      if (h_q) begin
        // Forcing the registers back to all-ones at the wrap keeps the
        // period at CHIPS even when CHIPS differs from the LFSR length.
        if (idx_q == 10'(CHIPS - 1)) begin
          idx_d   = '0;
          g1_d    = '1;
          g2_d    = '1;
          epoch_d = 1'b1;
        end else begin
          idx_d = idx_q + 10'd1;
          g1_d  = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
          g2_d  = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^
                              g2_q[9] ^ g2_q[10]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g1_q     <= '1;
      g2_q     <= '1;
      ta_q     <= 4'd2;
      tb_q     <= 4'd6;
      h_q      <= 1'b0;
      msb_q    <= 1'b0;
      idx_q    <= '0;
      prompt_q <= 1'b0;
      late_q   <= 1'b0;
      epoch_q  <= 1'b0;
    end else begin
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      ta_q     <= ta_d;
      tb_q     <= tb_d;
      h_q      <= h_d;
      // Tracks the MSB every cycle, including during load and while
      // disabled, so neither produces a spurious tick later.
      msb_q    <= code_phase_msb;
      idx_q    <= idx_d;
      prompt_q <= prompt_d;
      late_q   <= late_d;
      epoch_q  <= epoch_d;
    end
  end

  assign early      = early_w;
  assign prompt     = prompt_q;
  assign late       = late_q;
  assign chip_index = idx_q;
  assign epoch      = epoch_q;

endmodule

// File: tb/tb_ca_code_gen.sv
module tb_ca_code_gen;
  localparam int CHIPS = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] tap_a;
  logic [3:0] tap_b;
  logic       code_phase_msb;
  logic       early;
  logic       prompt;
  logic       late;
  logic [9:0] chip_index;
  logic       epoch;

  always #5 clk = ~clk;

  ca_code_gen #(.CHIPS(CHIPS)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .load          (load),
    .tap_a         (tap_a),
    .tap_b         (tap_b),
    .code_phase_msb(code_phase_msb),
    .early         (early),
    .prompt        (prompt),
    .late          (late),
    .chip_index    (chip_index),
    .epoch         (epoch)
  );

  // Reference: G1/G2 stage-10 output streams from the polynomial recurrences.
  // Stage t at chip k equals the stage-10 stream at k+10-t.
  bit g1s[CHIPS+10];
  bit g2s[CHIPS+10];

  int  errors = 0;
  int  checks = 0;

  int  m_k, m_h, m_ta, m_tb, m_ticks;
  bit  m_p, m_l, m_ep, m_prev;
  bit  cur_msb;
  int  dut_epochs;
  int  epoch_tick[$];
  bit  cap_en;
  bit  cap[10];

  function automatic bit sel(int t, int k);
    if (t >= 1 && t <= 10) return g2s[k + 10 - t];
    return 1'b0;
  endfunction

  function automatic bit code_at(int k);
    return g1s[k] ^ sel(m_ta, k) ^ sel(m_tb, k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_h = 0; m_p = 0; m_l = 0; m_ep = 0;
    m_ta = 2; m_tb = 6; m_prev = 0;
  endtask

  task automatic check_outs();
    chk("early",  early,      code_at(m_k));
    chk("prompt", prompt,     m_p);
    chk("late",   late,       m_l);
    chk("index",  chip_index, m_k);
    chk("epoch",  epoch,      m_ep);
  endtask

  // One clock: drive inputs, update the model at the edge, check #1 after.
  task automatic cycle(input bit en, input bit ld);
    bit e_pre, tk;
    code_phase_msb = cur_msb; enable = en; load = ld;
    e_pre = code_at(m_k);
    tk    = cur_msb ^ m_prev;
    @(posedge clk);
    m_ep = 0;
    if (ld) begin
      m_k = 0; m_h = 0; m_p = 0; m_l = 0;
      m_ta = tap_a; m_tb = tap_b; m_ticks = 0;
    end else if (tk && en) begin
      m_ticks++;
      m_l = m_p; m_p = e_pre;
      if (m_h == 1) begin
        m_k = (m_k + 1) % CHIPS;
        m_ep = (m_k == 0);
      end
      m_h ^= 1;
    end
    m_prev = cur_msb;
    #1;
    check_outs();
    if (epoch === 1'b1) begin
      dut_epochs++;
      epoch_tick.push_back(m_ticks);
    end
    if (cap_en && m_k < 10) cap[m_k] = early;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gap - 1; j++) cycle(1'b1, 1'b0);
      cur_msb = ~cur_msb;
      cycle(1'b1, 1'b0);
    end
  endtask

  task automatic run_rand_ticks(input int n);
    int got;
    got = 0;
    while (got < n) begin
      if ($urandom_range(0, 1) == 1) begin
        cur_msb = ~cur_msb;
        got++;
      end
      cycle(1'b1, 1'b0);
    end
  endtask

  function automatic logic [9:0] cap_word();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[9 - i] = cap[i];
    return w;
  endfunction

  initial begin
    int idx_hold, p_hold, l_hold, guard;

    for (int n = 0; n < 10; n++) begin g1s[n] = 1; g2s[n] = 1; end
    for (int n = 0; n < CHIPS; n++) begin
      g1s[n + 10] = g1s[n + 7] ^ g1s[n];
      g2s[n + 10] = g2s[n + 8] ^ g2s[n + 7] ^ g2s[n + 4] ^ g2s[n + 2] ^
                    g2s[n + 1] ^ g2s[n];
    end

    reset = 0; enable = 0; load = 0; tap_a = 0; tap_b = 0;
    code_phase_msb = 0; cur_msb = 0; dut_epochs = 0; m_ticks = 0; cap_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk("reset_early", early, 1);
    reset = 1;

    // PRN 1 from reset, MSB every 4th clock.
    cap_en = 1;
    run_ticks(20, 4);
    chk("prn1_first10", cap_word(), 10'o1440);
    cap_en = 0;

    // Load taps 3/7, then two code periods with random tick spacing.
    tap_a = 3; tap_b = 7;
    cycle(1'b1, 1'b1);
    dut_epochs = 0; epoch_tick.delete();
    cap_en = 1;
    run_ticks(20, 2);
    chk("t37_first10", cap_word(), 10'o1620);
    cap_en = 0;
    run_rand_ticks(2 * 2 * CHIPS - 20 + 3);
    chk("epoch_count", dut_epochs, 2);
    if (epoch_tick.size() >= 2) begin
      chk("epoch1_tick", epoch_tick[0], 2 * CHIPS);
      chk("epoch_spacing", epoch_tick[1] - epoch_tick[0], 2 * CHIPS);
    end else begin
      chk("epoch_ticks_seen", epoch_tick.size(), 2);
    end

    // Enable low for 50 ticks mid-code, then re-enable with a steady MSB.
    run_ticks(7, 3);
    idx_hold = chip_index; p_hold = prompt; l_hold = late;
    for (int i = 0; i < 50; i++) begin
      cur_msb = ~cur_msb;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
    end
    repeat (5) cycle(1'b1, 1'b0);
    chk("en_hold_index", chip_index, idx_hold);
    chk("en_hold_prompt", prompt, p_hold);
    chk("en_hold_late", late, l_hold);
    run_ticks(6, 2);

    // Load coincident with a tick at chip 500, invalid taps -> G1 only.
    guard = 0;
    while (m_k != 500 && guard < 5000) begin
      cur_msb = ~cur_msb; cycle(1'b1, 1'b0); guard++;
    end
    chk("reach_chip500", m_k, 500);
    tap_a = 0; tap_b = 12;
    cur_msb = ~cur_msb;
    cycle(1'b1, 1'b1);
    chk("load_tick_index", chip_index, 0);
    cap_en = 1;
    run_ticks(20, 2);
    chk("g1_only_first10", cap_word(), 10'h3FF);
    cap_en = 0;

    // Asynchronous reset at chip 700.
    guard = 0;
    while (m_k != 700 && guard < 5000) begin
      cur_msb = ~cur_msb; cycle(1'b1, 1'b0); guard++;
    end
    chk("reach_chip700", m_k, 700);
    #2 reset = 0;
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    reset = 1;
    cap_en = 1;
    run_ticks(20, 3);
    chk("after_reset_prn1", cap_word(), 10'o1440);
    cap_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
# ca_code_gen

GPS L1 C/A Gold-code generator that sits directly downstream of the code NCO. It watches the MSB of the code NCO phase accumulator and treats each MSB edge as a half-chip tick. From those ticks it produces early, prompt and late replica chips at half-chip spacing, plus a chip index and a code-epoch strobe, for the correlators and the tracking loop.

## Interface
Parameters:
- CHIPS, 1023, code length in chips; the chip index wraps at CHIPS-1.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous reset, active-low.
- enable  input  1  when low, ticks are ignored and all state holds. Edge tracking still runs.
- load  input  1  synchronous restart of the code; also latches tap_a and tap_b.
- tap_a  input  4  first G2 phase-select tap, valid range 1..10.
- tap_b  input  4  second G2 phase-select tap, valid range 1..10.
- code_phase_msb  input  1  bit WIDTH-1 of the code NCO phase_out.
- early  output  1  current generator chip.
- prompt  output  1  early delayed by one half-chip tick.
- late  output  1  early delayed by two half-chip ticks.
- chip_index  output  10  index of the current early chip, 0..CHIPS-1.
- epoch  output  1  one-cycle pulse when early starts chip 0.

## Operation
- Edge detection:
  - msb_d is a register that holds the previous cycle's code_phase_msb.
  - tick = code_phase_msb ^ msb_d, evaluated combinationally in the same cycle.
  - msb_d updates every cycle regardless of enable. On load, msb_d takes the current code_phase_msb, so load never produces a spurious tick.
- Accepted tick = tick & enable & ~load.
- Half-chip phase bit h:
  - On an accepted tick, h toggles.
  - If h was 1 before the toggle, the chip advances: G1, G2 and chip_index all step.
- G1 (bits 1..10):
  - Feedback = g1[3]^g1[10].
  - Shift: g1[1] <= feedback; g1[i] <= g1[i-1].
- G2 (bits 1..10):
  - Feedback = g2[2]^g2[3]^g2[6]^g2[8]^g2[9]^g2[10].
  - Shifts the same way as G1.
- early = g1[10] ^ sel(ta) ^ sel(tb), combinational from registered state.
  - ta and tb are the latched taps.
  - sel(t) = g2[t] for t in 1..10, else 0 (invalid tap contributes nothing).
- chip_index:
  - Increments on each chip advance.
  - CHIPS-1 -> 0 wraps; G1 and G2 are forced back to all-ones at the same edge.
  - This guarantees the period even when CHIPS is not 1023.
- On each accepted tick: late <= prompt; prompt <= early, using the pre-update value of early.
- epoch is registered. It is 1 for exactly one cycle after the edge at which chip_index wraps to 0. It is not asserted by load or by reset.
- load, priority over tick:
  - g1 and g2 go to all-ones; chip_index = 0; h = 0.
  - prompt and late go to 0; epoch goes to 0.
  - ta <= tap_a, tb <= tap_b.
- Reset values:
  - g1 and g2 all-ones; ta = 2, tb = 6 (PRN 1).
  - h = 0, msb_d = 0, chip_index = 0.
  - prompt = 0, late = 0, epoch = 0.
  - early therefore reads 1 (first PRN 1 chip).

## Timing
- Tick-to-output latency:
  - prompt, late, chip_index and generator state change one clock after the cycle in which the tick is seen.
  - early changes in that same cycle as the state change.
- A chip advances on every second accepted tick, so one chip spans two ticks and one code period spans 2*CHIPS ticks.
- code_phase_msb may toggle at most once per clock. The NCO step must stay below 2^(WIDTH-1) to meet this.
- Reset asserted mid-code forces all reset values immediately and asynchronously. After deassertion, operation resumes on the first clock edge.
- load and enable are both sampled on the rising edge. enable low combined with load high still performs the load.

## Test plan
- Reset, taps left at their reset value (PRN 1), MSB toggled on every 4th clock: the first 10 early chips are 1100100000 (octal 1440), and each chip is held for exactly 2 ticks.
- Load with tap_a=3, tap_b=7: the first 10 early chips are 1110010000 (octal 1620). prompt equals the previous early one tick later, and late equals the previous prompt.
- Run 2*1023 ticks from load:
  - epoch pulses once, for 1 cycle, when chip_index goes 1022 -> 0.
  - early at that point equals the chip-0 value again.
  - The next epoch follows exactly 2046 ticks later.
- Toggle enable low for 50 ticks mid-code: chip_index, h, prompt and late hold. No tick is seen on re-enable unless the MSB changes after that point.
- Load coincident with a tick at chip 500, with tap_a=0, tap_b=12: the tick is ignored, chip_index = 0, and early follows the G1-only sequence 1111111111 for the first 10 chips.
- Assert reset at chip 700: all outputs take their reset values asynchronously within the same cycle, and taps revert to 2/6.
